// File: rtl/count_frame_packer.sv
// ============================================================================
// count_frame_packer
// ----------------------------------------------------------------------------
// Splits each 2*COUNTSIZE count frame from the CDC receive stage into
// COUNTSIZE-wide words and writes them to the pipe-out FIFO, one word per
// g_clk. A frame starts only when the FIFO has room for all of it, so the
// FIFO never holds a partial frame. Frames that arrive while one is already
// pending are lost; they are counted and flagged as overflow.
//
// Optional feature (compile-time macro SEQ_TAG_EN):
//   defined   : each frame is preceded by a header word {16'hA5C3, seq[15:0]}.
//               seq advances on every g_valid, including lost frames, so the
//               host can spot gaps. Requires COUNTSIZE >= 32.
//   undefined : frames are bare word pairs (low half, then high half).
//
// Ports
//   g_clk            in   host-interface clock
//   c_rst            in   asynchronous, active-high reset
//   g_valid          in   one-cycle strobe, g_count holds a new frame
//   g_count          in   frame: [COUNTSIZE-1:0] up count, upper half down count
//   g_fifo_wr_count  in   FIFO write data count (words currently stored)
//   g_wr_en          out  FIFO write enable
//   g_din            out  FIFO write data (holds last value when g_wr_en=0)
//   g_busy           out  a frame is being written or is waiting
//   g_drop_count     out  frames lost, saturating at 32'hFFFF_FFFF
//   g_overflow       out  sticky: at least one frame lost since reset
// ============================================================================
module count_frame_packer #(
    parameter int COUNTSIZE   = 32,
    parameter int FIFO_DEPTH  = 8192,
    parameter int FIFO_MARGIN = 8,
    parameter int CNTW        = 13
) (
    input  logic                   g_clk,
    input  logic                   c_rst,
    input  logic                   g_valid,
    input  logic [2*COUNTSIZE-1:0] g_count,
    input  logic [CNTW-1:0]        g_fifo_wr_count,
    output logic                   g_wr_en,
    output logic [COUNTSIZE-1:0]   g_din,
    output logic                   g_busy,
    output logic [31:0]            g_drop_count,
    output logic                   g_overflow
);

`ifdef SEQ_TAG_EN
    localparam int WPF = 3;
`else
    localparam int WPF = 2;
`endif

    // Highest FIFO fill level at which a whole frame still fits.
    localparam int FIT_LIMIT = FIFO_DEPTH - FIFO_MARGIN - WPF;

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef SEQ_TAG_EN
    localparam logic [1:0] ST_HDR  = 2'd1;
`endif
    localparam logic [1:0] ST_W0   = 2'd2;
    localparam logic [1:0] ST_W1   = 2'd3;

    logic [1:0]             state;

    logic                   slot_full;
    logic [2*COUNTSIZE-1:0] slot_data;

    logic [COUNTSIZE-1:0]   emit_hi;
    logic [COUNTSIZE-1:0]   din_q;

    logic [31:0]            drop_count_q;
    logic                   overflow_q;

`ifdef SEQ_TAG_EN
    logic [15:0]            seq;
    logic [15:0]            slot_seq;
    logic [COUNTSIZE-1:0]   emit_lo;
`endif

    logic                   fits;
    logic                   start;
    logic                   accept;
    logic                   drop;

    assign fits = (32'(g_fifo_wr_count) <= 32'(FIT_LIMIT));

    // The slot is handed to the emitter on an idle cycle with room in the
    // FIFO. A frame arriving on that same cycle takes the freed slot
    // instead of being dropped.
    assign start  = (state == ST_IDLE) && slot_full && fits;
    assign accept = g_valid && (!slot_full || start);
    assign drop   = g_valid && slot_full && !start;

    // Single-entry pending slot.
    always_ff @(posedge g_clk or posedge c_rst) begin
        if (c_rst) begin
            slot_full <= 1'b0;
            slot_data <= '0;
        end else begin
            if (accept) begin
                slot_full <= 1'b1;
                slot_data <= g_count;
            end else if (start) begin
                slot_full <= 1'b0;
            end
        end
    end

`ifdef SEQ_TAG_EN
    // seq counts every arriving frame, lost ones included, and the value
    // current at arrival travels with the frame into the slot.
    always_ff @(posedge g_clk or posedge c_rst) begin
        if (c_rst) begin
            seq      <= '0;
            slot_seq <= '0;
        end else begin
            if (g_valid) begin
                seq <= seq + 16'd1;
            end
            if (accept) begin
                slot_seq <= seq;
            end
        end
    end
`endif

    // Emit FSM. g_din is registered and loaded on the edge that enters each
    // writing state, so the word for that state appears together with
    // g_wr_en and stays put afterwards.
    always_ff @(posedge g_clk or posedge c_rst) begin
        if (c_rst) begin
            state   <= ST_IDLE;
            din_q   <= '0;
            emit_hi <= '0;
`ifdef SEQ_TAG_EN
            emit_lo <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        emit_hi <= slot_data[2*COUNTSIZE-1:COUNTSIZE];
`ifdef SEQ_TAG_EN
                        emit_lo <= slot_data[COUNTSIZE-1:0];
                        din_q   <= COUNTSIZE'({16'hA5C3, slot_seq});
                        state   <= ST_HDR;
`else
                        din_q   <= slot_data[COUNTSIZE-1:0];
                        state   <= ST_W0;
`endif
                    end
                end
`ifdef SEQ_TAG_EN
                ST_HDR: begin
                    din_q <= emit_lo;
                    state <= ST_W0;
                end
`endif
                ST_W0: begin
                    din_q <= emit_hi;
                    state <= ST_W1;
                end
                ST_W1: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lost-frame accounting; the counter sticks at all-ones.
    always_ff @(posedge g_clk or posedge c_rst) begin
        if (c_rst) begin
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (drop) begin
            if (drop_count_q != 32'hFFFF_FFFF) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
            overflow_q <= 1'b1;
        end
    end

    assign g_wr_en      = (state != ST_IDLE);
    assign g_din        = din_q;
    assign g_busy       = (state != ST_IDLE) || slot_full;
    assign g_drop_count = drop_count_q;
    assign g_overflow   = overflow_q;

endmodule

// File: tb/tb_count_frame_packer.sv
// ============================================================================
// tb_count_frame_packer
// ----------------------------------------------------------------------------
// Self-checking bench for count_frame_packer. A queue-based reference model
// (pending frames, words still to be written, lost-frame tally) is advanced
// on every clock edge and compared with the DUT on every falling edge.
// Directed sequences with literal expectations pin the model, followed by a
// randomized run. Honors SEQ_TAG_EN the same way the design does.
// ============================================================================
module tb_count_frame_packer;

    localparam int CS     = 32;
    localparam int DEPTH  = 8192;
    localparam int MARGIN = 8;
    localparam int CW     = 13;
`ifdef SEQ_TAG_EN
    localparam int WPF = 3;
`else
    localparam int WPF = 2;
`endif
    localparam int LIMIT = DEPTH - MARGIN - WPF;

    logic            g_clk = 1'b0;
    logic            c_rst = 1'b0;
    logic            g_valid = 1'b0;
    logic [2*CS-1:0] g_count = '0;
    logic [CW-1:0]   g_fifo_wr_count = '0;
    logic            g_wr_en;
    logic [CS-1:0]   g_din;
    logic            g_busy;
    logic [31:0]     g_drop_count;
    logic            g_overflow;

    count_frame_packer #(
        .COUNTSIZE  (CS),
        .FIFO_DEPTH (DEPTH),
        .FIFO_MARGIN(MARGIN),
        .CNTW       (CW)
    ) dut (
        .g_clk          (g_clk),
        .c_rst          (c_rst),
        .g_valid        (g_valid),
        .g_count        (g_count),
        .g_fifo_wr_count(g_fifo_wr_count),
        .g_wr_en        (g_wr_en),
        .g_din          (g_din),
        .g_busy         (g_busy),
        .g_drop_count   (g_drop_count),
        .g_overflow     (g_overflow)
    );

    always #5 g_clk = ~g_clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [CS-1:0]   out_q[$];
    logic [2*CS-1:0] pend_cnt[$];
    logic [15:0]     pend_seq[$];
    logic [15:0]     m_seq = '0;
    longint unsigned m_ndrops = 0;
    logic            m_ovf = 1'b0;
    longint unsigned drop_base = 0;
    bit              check_en = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expDrops();
        longint unsigned sum;
        sum = drop_base + m_ndrops;
        if (sum > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return sum[31:0];
    endfunction

    function automatic logic [CS-1:0] firstWord(input logic [2*CS-1:0] cnt, input logic [15:0] s);
`ifdef SEQ_TAG_EN
        return {16'hA5C3, s};
`else
        return cnt[CS-1:0];
`endif
    endfunction

    // One clock edge of the reference model. Words in out_q are written one
    // per cycle; a new frame can only be taken on a cycle where nothing was
    // being written.
    task automatic modelStep();
        bit idle;
        if (c_rst) begin
            out_q.delete();
            pend_cnt.delete();
            pend_seq.delete();
            m_seq    = '0;
            m_ndrops = 0;
            m_ovf    = 1'b0;
            return;
        end
        idle = (out_q.size() == 0);
        if (!idle) void'(out_q.pop_front());
        if (idle && pend_cnt.size() > 0 && int'(g_fifo_wr_count) <= LIMIT) begin
`ifdef SEQ_TAG_EN
            out_q.push_back({16'hA5C3, pend_seq[0]});
`endif
            out_q.push_back(pend_cnt[0][CS-1:0]);
            out_q.push_back(pend_cnt[0][2*CS-1:CS]);
            void'(pend_cnt.pop_front());
            void'(pend_seq.pop_front());
        end
        if (g_valid) begin
            if (pend_cnt.size() == 0) begin
                pend_cnt.push_back(g_count);
                pend_seq.push_back(m_seq);
            end else begin
                m_ndrops++;
                m_ovf = 1'b1;
            end
            m_seq = m_seq + 16'd1;
        end
    endtask

    initial begin
        forever begin
            @(posedge g_clk or posedge c_rst);
            modelStep();
        end
    end

    task automatic checkOutput();
        bit exp_wr;
        exp_wr = (out_q.size() > 0);
        cmp("wr_en", 64'(g_wr_en), 64'(exp_wr));
        if (exp_wr) cmp("din", 64'(g_din), 64'(out_q[0]));
        cmp("busy", 64'(g_busy), 64'(out_q.size() > 0 || pend_cnt.size() > 0));
        cmp("drop_count", 64'(g_drop_count), 64'(expDrops()));
        cmp("overflow", 64'(g_overflow), 64'(m_ovf));
    endtask

    initial begin
        forever begin
            @(negedge g_clk);
            if (check_en) checkOutput();
        end
    end

    task automatic applyStimulus(input logic v, input logic [2*CS-1:0] cnt, input logic [CW-1:0] wc);
        @(negedge g_clk);
        g_valid         = v;
        g_count         = cnt;
        g_fifo_wr_count = wc;
    endtask

    task automatic idleCycles(input int n, input logic [CW-1:0] wc);
        repeat (n) applyStimulus(1'b0, g_count, wc);
    endtask

    task automatic doReset();
        @(negedge g_clk);
        #2;
        c_rst     = 1'b1;
        g_valid   = 1'b0;
        drop_base = 0;
        @(negedge g_clk);
        #2;
        c_rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        cmp({tag, "_wr_en"}, 64'(g_wr_en), 64'd0);
        cmp({tag, "_din"}, 64'(g_din), 64'd0);
        cmp({tag, "_busy"}, 64'(g_busy), 64'd0);
        cmp({tag, "_drop"}, 64'(g_drop_count), 64'd0);
        cmp({tag, "_ovf"}, 64'(g_overflow), 64'd0);
    endtask

    localparam logic [CW-1:0] WC_FULL = '1;

    initial begin
        logic [2*CS-1:0] f;
        logic [CW-1:0]   wc;
        int              r;

        // Reset state
        #1 c_rst = 1'b1;
        #2 checkAllZero("reset");
        @(negedge g_clk);
        #2 c_rst = 1'b0;
        check_en = 1'b1;

        // Single frame, first write two cycles after the strobe
        applyStimulus(1'b1, 64'h0000_0005_0000_0003, '0);
        applyStimulus(1'b0, 64'h0000_0005_0000_0003, '0);
        @(negedge g_clk);
`ifdef SEQ_TAG_EN
        cmp("t1_hdr_en", 64'(g_wr_en), 64'd1);
        cmp("t1_hdr", 64'(g_din), 64'hA5C3_0000);
        @(negedge g_clk);
`endif
        cmp("t1_w0_en", 64'(g_wr_en), 64'd1);
        cmp("t1_w0", 64'(g_din), 64'h3);
        @(negedge g_clk);
        cmp("t1_w1_en", 64'(g_wr_en), 64'd1);
        cmp("t1_w1", 64'(g_din), 64'h5);
        @(negedge g_clk);
        cmp("t1_done_en", 64'(g_wr_en), 64'd0);
        cmp("t1_done_busy", 64'(g_busy), 64'd0);

        // Three frames in sequence, seq tags 0,1,2
        doReset();
        for (int k = 0; k < 3; k++) begin
            f = {32'(k + 100), 32'(k + 1)};
            applyStimulus(1'b1, f, '0);
            applyStimulus(1'b0, f, '0);
            @(negedge g_clk);
            cmp("t2_first", 64'(g_din), 64'(firstWord(f, 16'(k))));
            idleCycles(4, '0);
        end
        cmp("t2_drops", 64'(g_drop_count), 64'd0);

        // FIFO threshold: one word too full holds the frame, at limit it goes
        doReset();
        f = 64'h1111_2222_3333_4444;
        applyStimulus(1'b1, f, CW'(LIMIT + 1));
        idleCycles(5, CW'(LIMIT + 1));
        cmp("t3_held_en", 64'(g_wr_en), 64'd0);
        cmp("t3_held_busy", 64'(g_busy), 64'd1);
        applyStimulus(1'b0, f, CW'(LIMIT));
        @(negedge g_clk);
        cmp("t3_go_en", 64'(g_wr_en), 64'd1);
        cmp("t3_go_din", 64'(g_din), 64'(firstWord(f, 16'd0)));
        idleCycles(5, CW'(LIMIT));

        // FIFO full: frame 1 waits, frames 2 and 3 are lost
        doReset();
        f = 64'hAAAA_0001_BBBB_0001;
        applyStimulus(1'b1, f, WC_FULL);
        idleCycles(2, WC_FULL);
        applyStimulus(1'b1, 64'hAAAA_0002_BBBB_0002, WC_FULL);
        applyStimulus(1'b1, 64'hAAAA_0003_BBBB_0003, WC_FULL);
        applyStimulus(1'b0, 64'hAAAA_0003_BBBB_0003, WC_FULL);
        cmp("t4_drops", 64'(g_drop_count), 64'd2);
        cmp("t4_ovf", 64'(g_overflow), 64'd1);
        applyStimulus(1'b0, 64'hAAAA_0003_BBBB_0003, '0);
        @(negedge g_clk);
        cmp("t4_first", 64'(g_din), 64'(firstWord(f, 16'd0)));
        idleCycles(6, '0);
        cmp("t4_idle_busy", 64'(g_busy), 64'd0);

        // Reset in the middle of a frame
        doReset();
        f = 64'h0000_00BB_0000_00AA;
        applyStimulus(1'b1, f, '0);
        applyStimulus(1'b0, f, '0);
        @(negedge g_clk);
`ifdef SEQ_TAG_EN
        @(negedge g_clk);
`endif
        cmp("t5_in_w0", 64'(g_din), 64'hAA);
        #2;
        c_rst     = 1'b1;
        drop_base = 0;
        #1 checkAllZero("t5_rst");
        @(negedge g_clk);
        #2 c_rst = 1'b0;
        f = 64'h0000_00DD_0000_00CC;
        applyStimulus(1'b1, f, '0);
        applyStimulus(1'b0, f, '0);
        @(negedge g_clk);
        cmp("t5_restart", 64'(g_din), 64'(firstWord(f, 16'd0)));
        idleCycles(5, '0);

        // Drop counter saturation
        doReset();
        @(negedge g_clk);
        #2;
        force dut.drop_count_q = 32'hFFFF_FFFD;
        drop_base = 64'h0000_0000_FFFF_FFFD;
        #1 release dut.drop_count_q;
        f = 64'h5555_6666_7777_8888;
        applyStimulus(1'b1, f, WC_FULL);
        repeat (4) applyStimulus(1'b1, 64'h0, WC_FULL);
        applyStimulus(1'b0, 64'h0, WC_FULL);
        cmp("t6_sat", 64'(g_drop_count), 64'hFFFF_FFFF);
        cmp("t6_ovf", 64'(g_overflow), 64'd1);
        idleCycles(8, '0);
        cmp("t6_ovf_sticky", 64'(g_overflow), 64'd1);
        doReset();
        cmp("t6_ovf_cleared", 64'(g_overflow), 64'd0);
        cmp("t6_drop_cleared", 64'(g_drop_count), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) doReset();
            r = int'($urandom_range(0, 9));
            if (r < 6)      wc = CW'($urandom_range(0, LIMIT - 1));
            else if (r < 8) wc = CW'(LIMIT + int'($urandom_range(0, 1)));
            else            wc = CW'($urandom_range(LIMIT + 1, DEPTH - 1));
            applyStimulus(($urandom_range(0, 99) < 40), {$urandom, $urandom}, wc);
        end
        idleCycles(10, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
